// File: rtl/instr_type.sv
// Shared instruction-type definitions: fence kinds and the fence controller state.
package instr_type;

    typedef enum logic [1:0] {
        fk_fence   = 2'd0,
        fk_fence_i = 2'd1,
        fk_invalid = 2'd2
    } fence_kind_t;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_DRAIN = 3'd1,
        FS_INVAL = 3'd2,
        FS_FLUSH = 3'd3,
        FS_DONE  = 3'd4
    } fence_state_t;

endpackage

// File: rtl/fence_ctrl.sv
// FENCE / FENCE.I sequencer: drains the store buffer, optionally invalidates the
// I-cache and flushes fetch, with a bounded wait in DRAIN and INVAL.
module fence_ctrl
    import instr_type::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  fence_kind_t req_kind,
    input  logic [31:0] req_pc,
    output logic        req_ready,
    output logic        sb_drain,
    input  logic        sb_empty,
    output logic        ic_inv_req,
    input  logic        ic_inv_ack,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        stall,
    output logic        done,
    output logic        illegal,
    output logic        timeout
);

    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    fence_state_t  state_q, state_d;
    fence_kind_t   kind_q, kind_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          illegal_q, illegal_d;
    logic          tmo_q, tmo_d;
    logic          cnt_hit;

    // Counter reaches TIMEOUT on this edge; exits are tested first so they win.
    assign cnt_hit = (cnt_q + CW'(1)) >= CW'(TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FS_IDLE;
            kind_q    <= fk_invalid;
            pc_q      <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        pc_d      = pc_q;
        cnt_d     = '0;
        illegal_d = 1'b0;
        tmo_d     = 1'b0;
        case (state_q)
            FS_IDLE: begin
                if (req_valid) begin
                    if (req_kind == fk_fence || req_kind == fk_fence_i) begin
                        kind_d  = req_kind;
                        pc_d    = req_pc + 32'd4;
                        state_d = FS_DRAIN;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            FS_DRAIN: begin
                if (sb_empty) begin
                    state_d = (kind_q == fk_fence_i) ? FS_INVAL : FS_DONE;
                end else if (cnt_hit) begin
                    state_d = FS_DONE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FS_INVAL: begin
                if (ic_inv_ack) begin
                    state_d = FS_FLUSH;
                end else if (cnt_hit) begin
                    state_d = FS_DONE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FS_FLUSH: state_d = FS_DONE;
            FS_DONE:  state_d = FS_IDLE;
            default:  state_d = FS_IDLE;
        endcase
    end

    // Moore outputs; req_ready is additionally masked by rst so it is low throughout reset.
    always_comb begin
        req_ready   = (state_q == FS_IDLE) && !rst;
        sb_drain    = (state_q == FS_DRAIN);
        ic_inv_req  = (state_q == FS_INVAL);
        flush       = (state_q == FS_FLUSH);
        redirect_pc = (state_q == FS_FLUSH) ? pc_q : 32'd0;
        stall       = (state_q != FS_IDLE);
        done        = (state_q == FS_DONE);
        illegal     = illegal_q;
        timeout     = tmo_q;
    end

endmodule

// File: tb/tb_fence_ctrl.sv
// Bench for fence_ctrl: directed table, reset corner cases and randomized fences
// checked cycle by cycle against a timeline model.
module tb_fence_ctrl;
    import instr_type::*;

    localparam int TMO = 4;

    typedef struct packed {
        logic        ready;
        logic        sb_drain;
        logic        ic_inv_req;
        logic        flush;
        logic        stall;
        logic        done;
        logic        illegal;
        logic        timeout;
        logic [31:0] rpc;
    } outs_t;

    typedef struct {
        fence_kind_t kind;
        logic [31:0] pc;
        int          d;
        int          a;
        int          e_done;
        bit          e_flush;
        logic [31:0] e_rpc;
        bit          e_tmo;
        bit          e_ill;
        int          e_stall;
    } vec_t;

    logic        clk, rst;
    logic        req_valid, req_ready, sb_drain, sb_empty, ic_inv_req, ic_inv_ack;
    logic        flush, stall, done, illegal, timeout;
    fence_kind_t req_kind;
    logic [31:0] req_pc, redirect_pc;
    outs_t       act;
    int          n_cmp, n_fail;

    fence_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_kind(req_kind), .req_pc(req_pc),
        .req_ready(req_ready),
        .sb_drain(sb_drain), .sb_empty(sb_empty),
        .ic_inv_req(ic_inv_req), .ic_inv_ack(ic_inv_ack),
        .flush(flush), .redirect_pc(redirect_pc),
        .stall(stall), .done(done), .illegal(illegal), .timeout(timeout)
    );

    assign act = {req_ready, sb_drain, ic_inv_req, flush, stall, done, illegal, timeout, redirect_pc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_o(input string name, input outs_t got, input outs_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_i(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic outs_t idle_o();
        outs_t o;
        o = '0;
        o.ready = 1'b1;
        return o;
    endfunction

    // Cycle-k outputs for one fence accepted at k=0: d = first DRAIN cycle with
    // sb_empty high, a = INVAL cycle (1-based) on which the ack pulses.
    function automatic outs_t model(fence_kind_t kind, logic [31:0] pc, int d, int a, int k);
        outs_t o;
        int    dn, in_n, done_c;
        bit    dto, ito, fl;
        o = idle_o();
        if (kind != fk_fence && kind != fk_fence_i) begin
            o.illegal = (k == 1);
            return o;
        end
        dto  = d > TMO;
        dn   = dto ? TMO : d;
        ito  = 1'b0;
        in_n = 0;
        if (kind == fk_fence_i && !dto) begin
            ito  = a > TMO;
            in_n = ito ? TMO : a;
        end
        fl     = (kind == fk_fence_i) && !dto && !ito;
        done_c = dn + in_n + 1 + (fl ? 1 : 0);
        if (k >= 1 && k <= done_c) begin
            o.ready = 1'b0;
            o.stall = 1'b1;
        end
        if (k >= 1 && k <= dn) o.sb_drain = 1'b1;
        else if (k > dn && k <= dn + in_n) o.ic_inv_req = 1'b1;
        else if (fl && k == dn + in_n + 1) begin
            o.flush = 1'b1;
            o.rpc   = pc + 32'd4;
        end else if (k == done_c) begin
            o.done    = 1'b1;
            o.timeout = dto | ito;
        end
        return o;
    endfunction

    task automatic run_txn(input fence_kind_t kind, input logic [31:0] pc, input int d, input int a,
                           input bit noise, output int done_c, output bit fl_seen,
                           output logic [31:0] rpc, output bit tmo_seen, output bit ill_seen,
                           output int stall_n);
        int    len, dn;
        bit    is_f;
        outs_t e;
        is_f = (kind == fk_fence || kind == fk_fence_i);
        dn   = (d > TMO) ? TMO : d;
        len  = 3;
        if (is_f) begin
            for (int k = 1; k < 40; k++) begin
                e = model(kind, pc, d, a, k);
                if (e.done) begin
                    len = k + 2;
                    break;
                end
            end
        end
        done_c = -1; fl_seen = 0; rpc = '0; tmo_seen = 0; ill_seen = 0; stall_n = 0;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            e = model(kind, pc, d, a, k);
            chk_o($sformatf("cycle k=%0d kind=%0d d=%0d a=%0d", k, kind, d, a), act, e);
            if (act.done && done_c < 0) done_c = k;
            if (act.flush) begin fl_seen = 1; rpc = act.rpc; end
            if (act.timeout) tmo_seen = 1;
            if (act.illegal) ill_seen = 1;
            if (act.stall) stall_n++;
            if (k == 0) begin
                req_valid = 1'b1;
                req_kind  = kind;
                req_pc    = pc;
            end else if (noise && is_f && k < len - 1) begin
                req_valid = 1'($urandom_range(0, 1));
                req_kind  = fence_kind_t'(2'($urandom_range(0, 2)));
                req_pc    = $urandom;
            end else begin
                req_valid = 1'b0;
            end
            sb_empty   = is_f ? (k >= d) : 1'($urandom_range(0, 1));
            ic_inv_ack = is_f ? (k == dn + a) : 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk_o("idle", act, idle_o());
            req_valid  = 1'b0;
            sb_empty   = 1'($urandom_range(0, 1));
            ic_inv_ack = 1'($urandom_range(0, 1));
        end
    endtask

    vec_t        tbl[8];
    int          done_c, stall_n;
    bit          fl_seen, tmo_seen, ill_seen;
    logic [31:0] rpc;

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; req_valid = 0; req_kind = fk_fence; req_pc = '0;
        sb_empty = 0; ic_inv_ack = 0;

        tbl[0] = '{fk_fence,   32'h0000_0100, 1, 1, 2, 0, 32'h0,         0, 0, 2};
        tbl[1] = '{fk_fence_i, 32'h0000_1000, 3, 2, 7, 1, 32'h0000_1004, 0, 0, 7};
        tbl[2] = '{fk_fence_i, 32'hFFFF_FFFC, 1, 1, 4, 1, 32'h0000_0000, 0, 0, 4};
        tbl[3] = '{fk_invalid, 32'h0000_0040, 1, 1, -1, 0, 32'h0,        0, 1, 0};
        tbl[4] = '{fk_fence,   32'h0000_0200, 9, 1, 5, 0, 32'h0,         1, 0, 5};
        tbl[5] = '{fk_fence,   32'h0000_0300, 4, 1, 5, 0, 32'h0,         0, 0, 5};
        tbl[6] = '{fk_fence_i, 32'h0000_0400, 2, 9, 7, 0, 32'h0,         1, 0, 7};
        tbl[7] = '{fk_fence_i, 32'h0000_0500, 2, 4, 8, 1, 32'h0000_0504, 0, 0, 8};

        // Power-on reset: everything low, including req_ready.
        @(negedge clk);
        chk_o("reset_outs", act, '0);
        @(negedge clk);
        chk_o("reset_outs2", act, '0);
        rst = 1'b0;
        #1 chk_o("post_reset_idle", act, idle_o());

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i].kind, tbl[i].pc, tbl[i].d, tbl[i].a, 1'b0,
                    done_c, fl_seen, rpc, tmo_seen, ill_seen, stall_n);
            chk_i($sformatf("tbl%0d done_cycle", i), done_c, tbl[i].e_done);
            chk_i($sformatf("tbl%0d flush", i), int'(fl_seen), int'(tbl[i].e_flush));
            chk_i($sformatf("tbl%0d redirect", i), int'(rpc), int'(tbl[i].e_rpc));
            chk_i($sformatf("tbl%0d timeout", i), int'(tmo_seen), int'(tbl[i].e_tmo));
            chk_i($sformatf("tbl%0d illegal", i), int'(ill_seen), int'(tbl[i].e_ill));
            chk_i($sformatf("tbl%0d stall_cycles", i), stall_n, tbl[i].e_stall);
        end

        // Reset while waiting in INVAL: outputs drop at once, no pulses afterwards.
        @(negedge clk);
        req_valid = 1'b1; req_kind = fk_fence_i; req_pc = 32'h0000_2000;
        sb_empty = 1'b1; ic_inv_ack = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk_i("rst_mid inval_entered", int'(ic_inv_req), 1);
        #2 rst = 1'b1;
        #1 chk_o("rst_mid immediate", act, '0);
        @(negedge clk);
        chk_o("rst_mid held", act, '0);
        rst = 1'b0;
        ic_inv_ack = 1'b1;
        #1 chk_o("rst_mid release", act, idle_o());
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_o($sformatf("rst_mid after%0d", i), act, idle_o());
        end
        ic_inv_ack = 1'b0;

        // Randomized fences with noise on inputs the controller must ignore.
        for (int i = 0; i < 40; i++) begin
            run_txn(fence_kind_t'(2'($urandom_range(0, 2))), $urandom,
                    int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), 1'b1,
                    done_c, fl_seen, rpc, tmo_seen, ill_seen, stall_n);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fence_ctrl.md
FENCE_CTRL -- requirements
Module: fence_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum cycles spent in DRAIN or INVAL before abort.
REQ-002 SHALL have port clk  in  1  clock, rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  in  1  decoded fence instruction is present.
REQ-005 SHALL have port req_kind  in  fence_kind_t  fk_fence / fk_fence_i / fk_invalid.
REQ-006 SHALL have port req_pc  in  32  PC of the fence instruction.
REQ-007 SHALL have port req_ready  out  1  controller can accept a request.
REQ-008 SHALL have port sb_drain  out  1  request store-buffer drain.
REQ-009 SHALL have port sb_empty  in  1  store buffer is empty.
REQ-010 SHALL have port ic_inv_req  out  1  request I-cache invalidate.
REQ-011 SHALL have port ic_inv_ack  in  1  invalidate is complete (1-cycle pulse).
REQ-012 SHALL have port flush  out  1  flush fetch/decode, 1-cycle pulse.
REQ-013 SHALL have port redirect_pc  out  32  refetch address, valid while flush=1.
REQ-014 SHALL have port stall  out  1  hold the upstream pipeline.
REQ-015 SHALL have port done  out  1  fence retired, 1-cycle pulse.
REQ-016 SHALL have port illegal  out  1  invalid fence funct3, 1-cycle pulse.
REQ-017 SHALL have port timeout  out  1  drain/invalidate aborted, 1-cycle pulse.

Function
REQ-018 SHALL implement the Moore FSM states IDLE, DRAIN, INVAL, FLUSH, DONE, with all outputs decoded from registered state.
REQ-019 SHALL accept a request when req_valid=1 and state=IDLE; req_ready=1 only in IDLE.
REQ-020 SHALL, on accepting fk_fence or fk_fence_i, latch the kind and req_pc+4 (mod 2^32), then enter DRAIN.
REQ-021 SHALL, on accepting fk_invalid, stay in IDLE and assert illegal for exactly the next cycle.
REQ-022 SHALL, in DRAIN, drive sb_drain=1 and stall=1.
REQ-023 SHALL leave DRAIN when sb_empty=1: to DONE for fk_fence, to INVAL for fk_fence_i.
REQ-024 SHALL, in INVAL, hold ic_inv_req=1 and stall=1 until ic_inv_ack=1, then enter FLUSH.
REQ-025 SHALL ignore ic_inv_ack outside INVAL.
REQ-026 SHALL, in FLUSH, drive flush=1, stall=1, and redirect_pc=latched PC+4 for one cycle, then enter DONE.
REQ-027 SHALL, in DONE, drive done=1 and stall=1 for one cycle, then enter IDLE.
REQ-028 SHALL keep stall=0 in IDLE.
REQ-029 SHALL set an 8-bit-or-wider wait counter to 0 on entry to DRAIN or INVAL and increment it each cycle spent there.
REQ-030 SHALL, when the counter reaches TIMEOUT without exit, pulse timeout, drop sb_drain/ic_inv_req, and enter DONE, skipping FLUSH.
REQ-031 SHALL give exit priority over timeout when sb_empty or ic_inv_ack arrives in the same cycle the counter reaches TIMEOUT.
REQ-032 SHALL have a minimum latency, accept to done, of 2 cycles for fk_fence and 4 cycles for fk_fence_i when sb_empty=1 and ic_inv_ack returns the cycle after ic_inv_req rises.
REQ-033 SHALL drive redirect_pc=0 whenever flush=0.

Reset
REQ-034 SHALL, while rst=1, force state=IDLE, counter=0, latched kind=fk_invalid, latched PC=0.
REQ-035 SHALL hold every output low during reset except req_ready, which is low while rst=1 and high from the first cycle after release.
REQ-036 SHALL abandon any in-flight fence on reset mid-operation, with no done, flush, or timeout pulse afterward.

Structure
REQ-037 SHALL take fence_kind_t from the shared instr_type package.
REQ-038 SHALL add fence_state_t (FSM state enum) to instr_type.
REQ-039 SHALL be a single module with no sub-modules; the wait counter is inline.

Verification
REQ-040 SHALL cover: fk_fence, sb_empty=1 -> stall for 2 cycles, done at cycle 2, flush never asserted.
REQ-041 SHALL cover: fk_fence_i, req_pc=0x0000_1000, sb_empty after 3 cycles, ic_inv_ack after 2 cycles -> flush with redirect_pc=0x0000_1004, then done.
REQ-042 SHALL cover: req_pc=0xFFFF_FFFC fence_i -> redirect_pc=0x0000_0000.
REQ-043 SHALL cover: fk_invalid -> one illegal pulse, stall stays 0, req_ready stays 1.
REQ-044 SHALL cover: TIMEOUT=4, sb_empty held 0 -> timeout pulse after 4 DRAIN cycles, then done, no flush.
REQ-045 SHALL cover: rst asserted during INVAL -> all outputs low immediately, IDLE after release, no done pulse.
